// File: rtl/gclk_mon_lcar.sv
// gclk_mon_lcar: receive-side monitor for the looped-back LED grayscale clock.
// Synchronises GCLK into clk, counts rising edges per vsync frame, and flags
// out-of-tolerance frames, GCLK activity while blanked, and GCLK stalls.
module gclk_mon_lcar #(
  parameter int GCLK_PER_FRAME = 16384,
  parameter int TOL            = 4,
  parameter int STALL_CYC      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gclk,
  input  logic        vsync,
  input  logic        blank,
  input  logic        ovp,
  output logic [15:0] frame_cnt,
  output logic        cnt_ok,
  output logic        cnt_err,
  output logic [7:0]  err_cnt,
  output logic        blank_viol,
  output logic        stall
);

  localparam logic [16:0] EXP_CNT   = 17'(GCLK_PER_FRAME);
  localparam logic [16:0] TOL_CNT   = 17'(TOL);
  localparam logic [15:0] STALL_LIM = 16'(STALL_CYC);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic [15:0] edge_cnt_q, edge_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        cnt_ok_q, cnt_ok_d;
  logic        cnt_err_q, cnt_err_d;
  logic        blank_viol_q, blank_viol_d;
  logic        stall_q, stall_d;

  logic        rise;
  logic        count_rise;
  logic [15:0] cnt_plus;
  logic [16:0] cnt_ext;
  logic [16:0] cnt_dev;
  logic        in_tol;

  // Rise detect on the synchronised copy; the frame total includes a rise
  // landing in the closing cycle, and the edge counter never wraps.
  assign rise       = s2_q & ~s3_q;
  assign count_rise = rise & ~blank;
  assign cnt_plus   = (count_rise && (edge_cnt_q != 16'hFFFF)) ? edge_cnt_q + 16'd1 : edge_cnt_q;
  assign cnt_ext    = {1'b0, cnt_plus};
  assign cnt_dev    = (cnt_ext >= EXP_CNT) ? (cnt_ext - EXP_CNT) : (EXP_CNT - cnt_ext);
  assign in_tol     = (cnt_dev <= TOL_CNT);

  // Three-flop synchroniser for the asynchronous GCLK loopback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= gclk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      edge_cnt_q   <= 16'd0;
      idle_cnt_q   <= 16'd0;
      frame_cnt_q  <= 16'd0;
      err_cnt_q    <= 8'd0;
      cnt_ok_q     <= 1'b0;
      cnt_err_q    <= 1'b0;
      blank_viol_q <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      err_cnt_q    <= err_cnt_d;
      cnt_ok_q     <= cnt_ok_d;
      cnt_err_q    <= cnt_err_d;
      blank_viol_q <= blank_viol_d;
      stall_q      <= stall_d;
    end
  end

  // Next-state: frame counting, verdicts, blank violations and stall detection.
  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    err_cnt_d    = err_cnt_q;
    cnt_ok_d     = 1'b0;
    cnt_err_d    = 1'b0;
    blank_viol_d = 1'b0;
    stall_d      = stall_q;

    unique case (state_q)
      ST_IDLE: begin
        edge_cnt_d = 16'd0;
        idle_cnt_d = 16'd0;
        stall_d    = 1'b0;
        // The first vsync only opens a frame; no verdict yet.
        if (vsync && !ovp) begin
          state_d = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (ovp) begin
          // Abort: drop the partial frame, keep the last reported values.
          state_d    = ST_IDLE;
          edge_cnt_d = 16'd0;
          idle_cnt_d = 16'd0;
          stall_d    = 1'b0;
        end else begin
          blank_viol_d = rise & blank;

          if (vsync) begin
            frame_cnt_d = cnt_plus;
            edge_cnt_d  = 16'd0;
            if (in_tol) begin
              cnt_ok_d = 1'b1;
            end else begin
              cnt_err_d = 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end
          end else begin
            edge_cnt_d = cnt_plus;
          end

          if (count_rise || blank || vsync) begin
            idle_cnt_d = 16'd0;
          end else if (idle_cnt_q != 16'hFFFF) begin
            idle_cnt_d = idle_cnt_q + 16'd1;
          end

          // vsync restarts the idle count but does not release a held stall.
          if (count_rise || blank) begin
            stall_d = 1'b0;
          end else if (idle_cnt_d == STALL_LIM) begin
            stall_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign frame_cnt  = frame_cnt_q;
  assign cnt_ok     = cnt_ok_q;
  assign cnt_err    = cnt_err_q;
  assign err_cnt    = err_cnt_q;
  assign blank_viol = blank_viol_q;
  assign stall      = stall_q;

endmodule
